conv_window_sched: RTL
======================

Name: conv_window_sched

Overview:
Sequences one 2-D convolution pass over a square IW x IW feature map with a square KW x KW kernel. Walks every output window and, for each window, issues one memory read request per kernel tap. It counts the returning data beats, drives the MAC/accumulator enables and hands each finished window result to the output stage over a valid/ready handshake. It runs after configuration (kernel, M0, C/N) is loaded and sits between the conv control FSM and the memory/MAC datapath.

Parameters:
DIM_W, 8, width of the IW/KW dimension fields and of all loop counters
ADDR_W, 16, memory word-address width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
i_start  input  1  start pulse; sampled only in IDLE
i_iw  input  DIM_W  input width IW; latched on accepted start
i_kw  input  DIM_W  kernel width KW; latched on accepted start
i_base_addr  input  ADDR_W  feature-map base address; latched on accepted start
o_valid_req  output  1  read request valid
i_ready_req  input  1  memory accepts request
o_addr  output  ADDR_W  read word address
i_valid_rsp  input  1  read data beat valid
o_ready_rsp  output  1  scheduler accepts data beat
o_enb_mac  output  1  MAC enable, equals response handshake
o_first_tap  output  1  first tap of window; datapath clears accumulator
o_last_tap  output  1  last tap of window
o_valid_res  output  1  window result valid
i_ready_res  input  1  result consumer ready
o_busy  output  1  high whenever state is not IDLE
o_done  output  1  one-cycle pulse, pass complete
o_err  output  1  one-cycle pulse, illegal configuration

Behaviour:
- Reset: state IDLE, all counters and latched config cleared, every output 0. Reset mid-pass aborts immediately. Responses arriving after reset are not accepted (o_ready_rsp=0 in IDLE).
- Derived value: OW = IW-KW+1. Counters: orow and ocol in 0..OW-1; krow and kcol in 0..KW-1 for requests; a separate response tap counter in 0..KW*KW-1.
- States:
  - IDLE: if i_start, latch config and go to CHECK. A start in any other state is ignored.
  - CHECK: if KW==0, IW==0 or KW>IW, assert o_err for this cycle and return to IDLE. Otherwise clear all counters and go to ISSUE.
  - ISSUE: o_valid_req=1. o_addr = base + (orow+krow)*IW + (ocol+kcol), computed modulo 2^ADDR_W. kcol advances on request handshake and wraps into krow. On the handshake of the last tap (krow=kcol=KW-1), go to WAIT.
  - WAIT: o_valid_req=0. Stay until the response count reaches KW*KW, then go to EMIT.
  - EMIT: o_valid_res=1, held until i_ready_res. On handshake, advance ocol (wrapping into orow). If this was the last window (orow=ocol=OW-1), go to DONE; otherwise reset krow/kcol/tap counter and go to ISSUE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- o_ready_rsp=1 in ISSUE and WAIT, 0 elsewhere. Responses may overlap requests in ISSUE. Memory latency is at least 1 cycle, so the response count never exceeds the request count.
- o_enb_mac = i_valid_rsp && o_ready_rsp.
  - o_first_tap = o_enb_mac when the tap counter is 0.
  - o_last_tap = o_enb_mac when the tap counter is KW*KW-1.
- o_addr and o_valid_req are combinational from state and counters. They stay stable while o_valid_req && !i_ready_req.
- Latency: start accepted at cycle t, CHECK at t+1, first o_valid_req at t+2. With i_ready_req held high, one request issues per cycle.
- The next window's requests start only after the current result handshake. There is no cross-window overlap.
- KW==IW gives exactly one window. KW==1 gives one tap per window with first_tap==last_tap.

Test Plan:
1. IW=4, KW=3, base=0x100, all readies high, 2-cycle memory latency -> 4 windows of 9 requests each (36 total). Window 0 addresses: 0x100,101,102,104,105,106,108,109,10A. Window 3 starts at 0x105. Exactly 4 o_valid_res handshakes, then o_done for one cycle, o_busy drops.
2. Same as test 1 with i_ready_req toggling 1010... and i_ready_res held low for 5 cycles each window -> o_addr is stable during stalls, o_valid_res is held, and the address sequence is unchanged.
3. IW=4, KW=5 (then KW=0) -> o_err high exactly one cycle at t+1, no o_valid_req, back in IDLE.
4. IW=KW=3 -> single window, 9 requests, first_tap on beat 1 and last_tap on beat 9. Also IW=3, KW=1 -> 9 windows, first_tap and last_tap both high on every beat.
5. Assert rst during WAIT of window 1 while responses are still in flight -> next cycle all outputs are 0 and the state is IDLE. Late i_valid_rsp produces no o_enb_mac. A fresh start then runs test 1 correctly.
6. i_start pulsed repeatedly during a pass -> ignored, and the pass result is identical to test 1.

Source files
------------

// File: rtl/conv_window_sched_if.sv
// Bundle of configuration, memory request/response and result handshake signals
// between conv_window_sched (master side) and the surrounding datapath (slave side).
interface conv_window_sched_if #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
);
  // A transfer occurs on a rising clk edge where valid && ready are both high;
  // once valid rises it stays high, with its payload stable, until that edge.
  logic              i_start;
  logic [DIM_W-1:0]  i_iw;
  logic [DIM_W-1:0]  i_kw;
  logic [ADDR_W-1:0] i_base_addr;
  logic              o_valid_req;
  logic              i_ready_req;
  logic [ADDR_W-1:0] o_addr;
  logic              i_valid_rsp;
  logic              o_ready_rsp;
  logic              o_enb_mac;
  logic              o_first_tap;
  logic              o_last_tap;
  logic              o_valid_res;
  logic              i_ready_res;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    input  i_start, i_iw, i_kw, i_base_addr, i_ready_req, i_valid_rsp, i_ready_res,
    output o_valid_req, o_addr, o_ready_rsp, o_enb_mac, o_first_tap, o_last_tap,
           o_valid_res, o_busy, o_done, o_err
  );

  modport slave (
    output i_start, i_iw, i_kw, i_base_addr, i_ready_req, i_valid_rsp, i_ready_res,
    input  o_valid_req, o_addr, o_ready_rsp, o_enb_mac, o_first_tap, o_last_tap,
           o_valid_res, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv_window_sched.sv
// Walks every output window of an IW x IW map with a KW x KW kernel, issuing one
// read per tap, counting returned beats and handing each window result downstream.
module conv_window_sched #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  conv_window_sched_if.master      bus,
  output logic [2:0]               dbg_state
);

  localparam int TAP_W = 2 * DIM_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  iw_q;
  logic [DIM_W-1:0]  kw_q;
  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0]  orow;
  logic [DIM_W-1:0]  ocol;
  logic [DIM_W-1:0]  krow;
  logic [DIM_W-1:0]  kcol;
  logic [TAP_W-1:0]  tap_cnt;

  logic [DIM_W-1:0]  ow_m1;
  logic [TAP_W-1:0]  taps;
  logic              cfg_bad;
  logic              kcol_last;
  logic              krow_last;
  logic              last_win;
  logic              req_hs;
  logic              rsp_hs;
  logic [ADDR_W-1:0] row_idx;
  logic [ADDR_W-1:0] col_idx;

  assign ow_m1     = iw_q - kw_q;
  assign taps      = TAP_W'(kw_q) * TAP_W'(kw_q);
  assign cfg_bad   = (kw_q == '0) || (iw_q == '0) || (kw_q > iw_q);
  assign kcol_last = (kcol == kw_q - DIM_W'(1));
  assign krow_last = (krow == kw_q - DIM_W'(1));
  assign last_win  = (orow == ow_m1) && (ocol == ow_m1);

  // Address arithmetic deliberately wraps at ADDR_W bits.
  assign row_idx = ADDR_W'(orow) + ADDR_W'(krow);
  assign col_idx = ADDR_W'(ocol) + ADDR_W'(kcol);

  assign bus.o_valid_req = (state == S_ISSUE);
  assign bus.o_addr      = base_q + row_idx * ADDR_W'(iw_q) + col_idx;
  assign bus.o_ready_rsp = (state == S_ISSUE) || (state == S_WAIT);
  assign rsp_hs          = bus.i_valid_rsp && bus.o_ready_rsp;
  assign req_hs          = bus.o_valid_req && bus.i_ready_req;
  assign bus.o_enb_mac   = rsp_hs;
  assign bus.o_first_tap = rsp_hs && (tap_cnt == '0);
  assign bus.o_last_tap  = rsp_hs && (tap_cnt == taps - TAP_W'(1));
  assign bus.o_valid_res = (state == S_EMIT);
  assign bus.o_busy      = (state != S_IDLE);
  assign bus.o_done      = (state == S_DONE);
  assign bus.o_err       = (state == S_CHECK) && cfg_bad;
  assign dbg_state       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      iw_q    <= '0;
      kw_q    <= '0;
      base_q  <= '0;
      orow    <= '0;
      ocol    <= '0;
      krow    <= '0;
      kcol    <= '0;
      tap_cnt <= '0;
    end else begin
      // Beats can land while requests are still issuing, so count them outside the case.
      if (rsp_hs) tap_cnt <= tap_cnt + TAP_W'(1);
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            iw_q   <= bus.i_iw;
            kw_q   <= bus.i_kw;
            base_q <= bus.i_base_addr;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_bad) begin
            state <= S_IDLE;
          end else begin
            orow    <= '0;
            ocol    <= '0;
            krow    <= '0;
            kcol    <= '0;
            tap_cnt <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_hs) begin
            if (kcol_last) begin
              kcol <= '0;
              if (krow_last) state <= S_WAIT;
              else           krow  <= krow + DIM_W'(1);
            end else begin
              kcol <= kcol + DIM_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (tap_cnt == taps) state <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.i_ready_res) begin
            krow    <= '0;
            kcol    <= '0;
            tap_cnt <= '0;
            if (last_win) begin
              state <= S_DONE;
            end else begin
              if (ocol == ow_m1) begin
                ocol <= '0;
                orow <= orow + DIM_W'(1);
              end else begin
                ocol <= ocol + DIM_W'(1);
              end
              state <= S_ISSUE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
